// File: rtl/dmem_stall_adapter.sv
// Bridges the M-stage single-cycle dmem port to a val/rdy request and val-only
// response memory, stalling the pipeline until the response has been captured.
module dmem_stall_adapter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmemreq_val,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic [31:0] dmemresp_rdata,
  output logic        stall,
  output logic        memreq_val,
  input  logic        memreq_rdy,
  output logic        memreq_type,
  output logic [31:0] memreq_addr,
  output logic [31:0] memreq_wdata,
  input  logic        memresp_val,
  input  logic [31:0] memresp_rdata,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam bit            TIMEOUT_EN = (TIMEOUT != 0);
  localparam int unsigned   TO_LAST_I  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CW-1:0] TO_LAST    = CW'(TO_LAST_I);

  state_t        state_q, state_d;
  logic          type_q,  type_d;
  logic [31:0]   addr_q,  addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          err_q,   err_d;

  always_comb begin
    state_d        = state_q;
    type_d         = type_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    stall          = 1'b0;
    memreq_val     = 1'b0;
    dmemresp_rdata = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (dmemreq_val) begin
          type_d  = dmemreq_type;
          addr_d  = dmemreq_addr;
          wdata_d = dmemreq_wdata;
          state_d = S_REQ;
          // A request presented while reset is held is not accepted, so no stall.
          stall   = ~rst;
        end
      end

      S_REQ: begin
        memreq_val = 1'b1;
        stall      = 1'b1;
        if (memreq_rdy) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        stall = 1'b1;
        if (memresp_val) begin
          rdata_d = type_q ? 32'd0 : memresp_rdata;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (TIMEOUT_EN && (cnt_q == TO_LAST)) begin
            err_d   = 1'b1;
            rdata_d = 32'd0;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        // The completing request is still visible on dmemreq_val here; ignore it.
        dmemresp_rdata = rdata_q;
        state_d        = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      type_q  <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign memreq_type  = type_q;
  assign memreq_addr  = addr_q;
  assign memreq_wdata = wdata_q;
  assign err          = err_q;

endmodule

// File: tb/tb_dmem_stall_adapter.sv
// Transaction-level checks of dmem_stall_adapter: each transaction's stall length,
// request count, field stability, returned data and err are predicted arithmetically.
module tb_dmem_stall_adapter;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmemreq_val;
  logic        dmemreq_type;
  logic [31:0] dmemreq_addr;
  logic [31:0] dmemreq_wdata;
  logic [31:0] dmemresp_rdata;
  logic        stall;
  logic        memreq_val;
  logic        memreq_rdy;
  logic        memreq_type;
  logic [31:0] memreq_addr;
  logic [31:0] memreq_wdata;
  logic        memresp_val;
  logic [31:0] memresp_rdata;
  logic        err;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  bit err_model = 1'b0;

  dmem_stall_adapter #(.TIMEOUT(TIMEOUT), .CW(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .dmemreq_val   (dmemreq_val),
    .dmemreq_type  (dmemreq_type),
    .dmemreq_addr  (dmemreq_addr),
    .dmemreq_wdata (dmemreq_wdata),
    .dmemresp_rdata(dmemresp_rdata),
    .stall         (stall),
    .memreq_val    (memreq_val),
    .memreq_rdy    (memreq_rdy),
    .memreq_type   (memreq_type),
    .memreq_addr   (memreq_addr),
    .memreq_wdata  (memreq_wdata),
    .memresp_val   (memresp_val),
    .memresp_rdata (memresp_rdata),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Idle cycles: memory-side noise must not disturb an idle adapter.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dmemreq_val   = 1'b0;
      dmemreq_type  = 1'($urandom_range(0, 1));
      dmemreq_addr  = $urandom;
      dmemreq_wdata = $urandom;
      memreq_rdy    = 1'($urandom_range(0, 1));
      memresp_val   = 1'($urandom_range(0, 1));
      memresp_rdata = $urandom;
      #1;
      chk("idle_stall", {31'd0, stall}, 32'd0);
      chk("idle_memreq_val", {31'd0, memreq_val}, 32'd0);
      chk("idle_rdata", dmemresp_rdata, 32'd0);
    end
  endtask

  // rdy_dly: REQ cycles with rdy low before acceptance.
  // resp_dly: WAIT cycle (1-based) carrying the response; > TIMEOUT means no response.
  task automatic run_txn(input logic typ, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int rdy_dly, input int resp_dly,
                         input bit squash);
    int w, stall_cnt, reqv_cnt, bad_fields, early_data, done_cyc, accept_cyc, resp_cyc;
    bit timed_out;
    logic [31:0] exp_data, got_data;
    logic got_err;
    timed_out  = (resp_dly > TIMEOUT);
    w          = timed_out ? TIMEOUT : resp_dly;
    exp_data   = (timed_out || typ) ? 32'd0 : rdata;
    if (timed_out) err_model = 1'b1;
    accept_cyc = rdy_dly + 1;
    resp_cyc   = timed_out ? -1 : accept_cyc + resp_dly;
    stall_cnt  = 0; reqv_cnt = 0; bad_fields = 0; early_data = 0; done_cyc = -1;
    got_data   = 32'd0; got_err = 1'b0;

    for (int cyc = 0; cyc < 64 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (squash && cyc > 0) begin
        dmemreq_val   = 1'b0;
        dmemreq_type  = ~typ;
        dmemreq_addr  = $urandom;
        dmemreq_wdata = $urandom;
      end else begin
        dmemreq_val   = 1'b1;
        dmemreq_type  = typ;
        dmemreq_addr  = addr;
        dmemreq_wdata = wdata;
      end
      memreq_rdy    = (cyc == accept_cyc);
      memresp_rdata = $urandom;
      if (cyc == resp_cyc) begin
        memresp_val   = 1'b1;
        memresp_rdata = rdata;
      end else if (cyc == 0 || cyc == accept_cyc) begin
        memresp_val = 1'($urandom_range(0, 1));
      end else begin
        memresp_val = 1'b0;
      end
      #1;
      if (stall) stall_cnt++;
      if (memreq_val) begin
        reqv_cnt++;
        if (memreq_type !== typ || memreq_addr !== addr || memreq_wdata !== wdata) bad_fields++;
      end
      if (cyc > 0 && !stall) begin
        done_cyc = cyc;
        got_data = dmemresp_rdata;
        got_err  = err;
      end else if (dmemresp_rdata !== 32'd0) begin
        early_data++;
      end
    end

    chk("done_reached", {31'd0, done_cyc >= 0}, 32'd1);
    chk("latency", done_cyc, 1 + accept_cyc + w);
    chk("stall_cycles", stall_cnt, 1 + rdy_dly + 1 + w);
    chk("memreq_cycles", reqv_cnt, rdy_dly + 1);
    chk("field_stable", bad_fields, 0);
    chk("rdata_outside_done", early_data, 0);
    chk("rdata", got_data, exp_data);
    chk("err", {31'd0, got_err}, {31'd0, err_model});
    $display("txn type=%0d addr=%h rdy_dly=%0d resp_dly=%0d squash=%0d stall=%0d rdata=%h err=%0d",
             typ, addr, rdy_dly, resp_dly, squash, stall_cnt, got_data, got_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; dmemreq_val = 1'b0; dmemreq_type = 1'b0; dmemreq_addr = 32'd0;
    dmemreq_wdata = 32'd0; memreq_rdy = 1'b0; memresp_val = 1'b0; memresp_rdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_memreq_val", {31'd0, memreq_val}, 32'd0);
    chk("rst_rdata", dmemresp_rdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_addr", memreq_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(2);

    run_txn(1'b0, 32'h0000_0100, 32'd0, 32'h1234_5678, 0, 1, 1'b0);
    idle_cycles(1);
    run_txn(1'b1, 32'h0000_0200, 32'hCAFE_F00D, 32'hDEAD_BEEF, 4, 2, 1'b0);
    idle_cycles(1);
    run_txn(1'b0, 32'h0000_0010, 32'd0, 32'h1111_2222, 0, 1, 1'b0);
    run_txn(1'b0, 32'h0000_0014, 32'd0, 32'h3333_4444, 0, 1, 1'b0);
    idle_cycles(1);
    run_txn(1'b0, 32'h0000_0300, 32'd0, 32'h5555_6666, 1, TIMEOUT, 1'b0);
    run_txn(1'b0, 32'h0000_0400, 32'd0, 32'h7777_8888, 0, 99, 1'b0);
    run_txn(1'b0, 32'h0000_0404, 32'd0, 32'hA5A5_A5A5, 0, 1, 1'b0);
    run_txn(1'b0, 32'h0000_0500, 32'd0, 32'h0BAD_F00D, 2, 3, 1'b1);

    for (int t = 0; t < 24; t++) begin
      int rd, rp;
      rd = $urandom_range(0, 4);
      rp = ($urandom_range(0, 5) == 0) ? TIMEOUT + 3 : $urandom_range(1, TIMEOUT);
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, rd, rp,
              ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
    end

    // Reset while waiting for a response; a late response must be ignored.
    @(negedge clk);
    dmemreq_val = 1'b1; dmemreq_type = 1'b0; dmemreq_addr = 32'h0000_0600;
    memreq_rdy = 1'b0; memresp_val = 1'b0;
    @(negedge clk); memreq_rdy = 1'b1;
    @(negedge clk); memreq_rdy = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; dmemreq_val = 1'b0; memresp_val = 1'b1; memresp_rdata = 32'hFEED_FACE;
    err_model = 1'b0;
    #1;
    chk("rstw_stall", {31'd0, stall}, 32'd0);
    chk("rstw_memreq_val", {31'd0, memreq_val}, 32'd0);
    chk("rstw_rdata", dmemresp_rdata, 32'd0);
    chk("rstw_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    memresp_val = 1'b0;
    #1;
    chk("rstw_after_rdata", dmemresp_rdata, 32'd0);
    chk("rstw_after_stall", {31'd0, stall}, 32'd0);
    idle_cycles(1);
    run_txn(1'b0, 32'h0000_0700, 32'd0, 32'h1357_9BDF, 1, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_stall_adapter.md
Name: dmem_stall_adapter

Overview:
- Sits directly downstream of the processor datapath's M-stage data-memory port (`dmemreq_*` / `dmemresp_rdata`).
- Converts the single-cycle, combinational-response dmem interface into a val/rdy request channel and a val-only response channel to a multi-cycle memory.
- Asserts `stall` to the processor control unit until the response is ready, then presents the read data for exactly one cycle.
- Tracks a per-transaction timeout and holds a sticky error flag.

Parameters:
- `TIMEOUT`, default 255: maximum number of WAIT-state cycles before the transaction is aborted. 0 disables the timeout.
- `CW`, default 8: width of the timeout counter. The requirement TIMEOUT < 2^CW is fixed.

Ports:
- `clk` input 1: clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `dmemreq_val` input 1: processor M-stage memory request valid.
- `dmemreq_type` input 1: 0 = load, 1 = store.
- `dmemreq_addr` input 32: byte address.
- `dmemreq_wdata` input 32: store data.
- `dmemresp_rdata` output 32: load data returned to the M stage.
- `stall` output 1: to control; 1 means hold the M stage and everything upstream.
- `memreq_val` output 1: memory request valid.
- `memreq_rdy` input 1: memory accepts the request.
- `memreq_type` output 1: captured type.
- `memreq_addr` output 32: captured address.
- `memreq_wdata` output 32: captured store data.
- `memresp_val` input 1: memory response valid (load data or store ack).
- `memresp_rdata` input 32: memory response data.
- `err` output 1: sticky timeout error.

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset: state = IDLE, captured type/addr/wdata/rdata = 0, timeout count = 0, `err` = 0.
  - Outputs during and after reset: `memreq_val` = 0, `stall` = 0, `dmemresp_rdata` = 0.
- IDLE:
  - If `dmemreq_val`=1: capture type, addr and wdata; go to REQ. `stall` = 1 combinationally in this cycle.
  - If `dmemreq_val`=0: stay in IDLE; `stall` = 0.
  - `memresp_val` is ignored in IDLE.
- REQ:
  - `memreq_val` = 1 with the captured fields; `stall` = 1.
  - `memreq_val` is held until `memreq_rdy`=1. Fields never change while `memreq_val`=1.
  - On `memreq_val` && `memreq_rdy`: go to WAIT and clear the timeout count.
- WAIT:
  - `memreq_val` = 0; `stall` = 1.
  - On `memresp_val`=1: capture `memresp_rdata` for a load, or 0 for a store; go to DONE.
  - Otherwise the count increments. If TIMEOUT != 0 and count == TIMEOUT-1 with no response: set `err`=1, captured rdata = 0, go to DONE.
- DONE:
  - `stall` = 0; `dmemresp_rdata` = captured rdata for this cycle only; next state is IDLE unconditionally.
  - The processor's `dmemreq_val` is still 1 in DONE for the completing request. It must not start a new transaction.
- `dmemresp_rdata` = 0 in every state except DONE.
- Latency:
  - Zero-wait memory (`rdy`=1 in REQ, `memresp_val`=1 in the first WAIT cycle): request seen at cycle t, REQ at t+1, WAIT at t+2, DONE at t+3. That is 3 stall cycles, data on cycle t+3.
  - Minimum spacing between back-to-back requests is 4 cycles (DONE → IDLE → accept).
- Processor obligations: the request fields are held stable while `stall`=1. The adapter uses only captured copies, so a `dmemreq_val` drop mid-transaction (squash) does not abort it; the transaction completes, and `stall` still goes low only in DONE.
- Simultaneous events:
  - `memreq_rdy` and `memresp_val` in the same REQ cycle: the response is ignored. Memory must respond no earlier than the cycle after acceptance.
  - Response arriving in the same cycle the timeout would fire: the response wins and `err` is unchanged.
- Reset mid-operation (any state): return to IDLE next edge; `memreq_val` drops that edge; a late `memresp_val` after reset is ignored.
- `err` is cleared only by `rst`.

Test Plan:
- Load, zero-wait memory:
  - Stimulus: `dmemreq_val`=1, type=0, addr=0x00000100; memory returns 0x12345678 one cycle after accept.
  - Required response: `stall` high for 3 cycles; `memreq_addr`=0x100 with `memreq_val` high for 1 cycle; `dmemresp_rdata`=0x12345678 in DONE only, 0 the next cycle.
- Store with backpressure:
  - Stimulus: type=1, addr=0x200, wdata=0xCAFEF00D; `memreq_rdy`=0 for 4 cycles, then 1; ack 2 cycles later.
  - Required response: `memreq_*` stable across all 5 request cycles; `stall` high for 1+5+2 = 8 cycles; `dmemresp_rdata`=0 in DONE.
- Back-to-back:
  - Stimulus: load 0x10, then `dmemreq_val` held high with new addr 0x14 right after DONE.
  - Required response: exactly 2 memory requests; the second is accepted in the IDLE cycle following DONE; no duplicate request for 0x10.
- Timeout:
  - Stimulus: TIMEOUT=4; request accepted, no response.
  - Required response: DONE after 4 WAIT cycles; `err`=1 and stays 1; `dmemresp_rdata`=0. A subsequent normal load (data 0xA5A5A5A5) completes correctly with `err` still 1.
- Reset mid-WAIT:
  - Stimulus: assert `rst` in a WAIT cycle; `memresp_val` pulses the cycle after.
  - Required response: state IDLE, `stall`=0, `memreq_val`=0, `dmemresp_rdata`=0; the pulse has no effect; `err`=0.
- Squash: `dmemreq_val` drops in REQ → the transaction still completes with the captured addr; `stall` falls only in DONE.
